// File: rtl/bp_perf_pkg.sv
// bp_perf_pkg: shared channel enumeration and helpers for the performance counter bank
// Exports bp_perf_event_e (default channel map), bp_perf_els_gp (channel count), safe_clog2.
package bp_perf_pkg;
  typedef enum logic [2:0] {
    e_perf_mcycle,
    e_perf_minstret,
    e_perf_fe_wait,
    e_perf_fe_queue_stall,
    e_perf_dcache_miss,
    e_perf_icache_miss,
    e_perf_branch_mispredict,
    e_perf_unknown
  } bp_perf_event_e;
  localparam int bp_perf_els_gp = int'(e_perf_unknown) + 1;
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bp_perf_counter.sv
// bp_perf_counter: one live event counter with wrap/saturate and sticky overflow flag
// Ports: clk_i, reset_n_i (sync, active-low), clear_i (zero count and flag),
//        inc_i (qualified event strobe), cnt_o (live count), overflow_o (sticky flag).
// Macro: BP_PERF_OVERFLOW_IRQ_EN enables the overflow flag; otherwise overflow_o is 0.
module bp_perf_counter #(
  parameter int width_p    = 32,
  parameter bit saturate_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [width_p-1:0] cnt_o,
  output logic               overflow_o
);
  logic [width_p-1:0] cnt_q, cnt_d;
  logic at_max;
  assign at_max = &cnt_q;
  assign cnt_o  = cnt_q;
  always_comb cnt_d = clear_i ? '0 : !inc_i ? cnt_q : (at_max && saturate_p) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`ifdef BP_PERF_OVERFLOW_IRQ_EN
  logic ovf_q, ovf_d;
  // an event arriving at all-ones either wraps or is lost to saturation
  always_comb ovf_d = clear_i ? 1'b0 : ovf_q | (inc_i & at_max);
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif
endmodule

// File: rtl/bp_perf_counter_bank.sv
// bp_perf_counter_bank: els_p event counters with atomic snapshot and buffered valid/ready read port
// Ports: clk_i, reset_n_i (sync, active-low), en_i, clear_i, event_i[els_p], snapshot_i,
//        rd_v_i/rd_ready_and_o/rd_addr_i (request), rd_v_o/rd_data_o/rd_yumi_i (response),
//        overflow_o[els_p] (sticky flags), irq_o (registered OR of flags).
// Macro: BP_PERF_OVERFLOW_IRQ_EN enables overflow flags and irq; otherwise both read 0.
module bp_perf_counter_bank
  import bp_perf_pkg::*;
#(
  parameter int els_p         = bp_perf_els_gp,
  parameter int width_p       = 32,
  parameter bit saturate_p    = 1'b0,
  parameter int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic [els_p-1:0]         event_i,
  input  logic                     snapshot_i,
  input  logic                     rd_v_i,
  output logic                     rd_ready_and_o,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic                     rd_v_o,
  output logic [width_p-1:0]       rd_data_o,
  input  logic                     rd_yumi_i,
  output logic [els_p-1:0]         overflow_o,
  output logic                     irq_o
);
  logic [width_p-1:0] cnt      [els_p];
  logic [width_p-1:0] shadow_q [els_p];
  logic [els_p-1:0]   ovf;
  for (genvar k = 0; k < els_p; k++) begin : g_ch
    bp_perf_counter #(.width_p(width_p), .saturate_p(saturate_p)) u_cnt (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .clear_i    (clear_i),
      .inc_i      (en_i & event_i[k]),
      .cnt_o      (cnt[k]),
      .overflow_o (ovf[k])
    );
    // shadow captures the pre-update count, so snapshot with clear loses nothing
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) shadow_q[k] <= '0;
      else if (snapshot_i) shadow_q[k] <= cnt[k];
    end
  end
  logic [width_p-1:0] rd_mux, rd_data_q, rd_data_d;
  logic rd_v_q, rd_v_d, irq_q, accept;
  // unmatched (out-of-range) addresses fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < els_p; k++)
      if (rd_addr_i == addr_width_lp'(k)) rd_mux = shadow_q[k];
  end
  assign rd_ready_and_o = ~rd_v_q | rd_yumi_i;
  assign accept         = rd_v_i & rd_ready_and_o;
  always_comb begin
    rd_v_d    = accept | (rd_v_q & ~rd_yumi_i);
    rd_data_d = accept ? rd_mux : rd_data_q;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      rd_v_q    <= rd_v_d;
      rd_data_q <= rd_data_d;
      irq_q     <= |ovf;
    end
  end
  assign rd_v_o     = rd_v_q;
  assign rd_data_o  = rd_data_q;
  assign overflow_o = ovf;
  assign irq_o      = irq_q;
  always_ff @(posedge clk_i) begin
    if (reset_n_i) assert (!(rd_yumi_i && !rd_v_q));
  end
endmodule

// File: tb/tb_bp_perf_counter_bank.sv
// tb_bp_perf_counter_bank: randomized scoreboard bench for wrap and saturate counter banks
module tb_bp_perf_counter_bank;
  localparam int N = 5;
  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, en, clr, snap, rv, yumi, yumi_req;
  logic [N-1:0] ev;
  logic [2:0] raddr;
  logic rdy_w, rdy_s, rvo_w, rvo_s, irq_w_o, irq_s_o;
  logic [W-1:0] rdo_w, rdo_s;
  logic [N-1:0] ovf_w_o, ovf_s_o;
  bp_perf_counter_bank #(.els_p(N), .width_p(W), .saturate_p(1'b0)) u_wrap (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .clear_i(clr), .event_i(ev),
    .snapshot_i(snap), .rd_v_i(rv), .rd_ready_and_o(rdy_w), .rd_addr_i(raddr),
    .rd_v_o(rvo_w), .rd_data_o(rdo_w), .rd_yumi_i(yumi), .overflow_o(ovf_w_o), .irq_o(irq_w_o));
  bp_perf_counter_bank #(.els_p(N), .width_p(W), .saturate_p(1'b1)) u_sat (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .clear_i(clr), .event_i(ev),
    .snapshot_i(snap), .rd_v_i(rv), .rd_ready_and_o(rdy_s), .rd_addr_i(raddr),
    .rd_v_o(rvo_s), .rd_data_o(rdo_s), .rd_yumi_i(yumi), .overflow_o(ovf_s_o), .irq_o(irq_s_o));
  int pass_cnt = 0;
  int total = 0;
  int lw[N], ls[N], shw[N], shs[N];
  bit ovw[N], ovs[N];
  bit irqw, irqs, mv;
  int qw[$], qs[$];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  function automatic int flags(input bit f[N]);
    int v = 0;
`ifdef BP_PERF_OVERFLOW_IRQ_EN
    for (int k = 0; k < N; k++) if (f[k]) v |= (1 << k);
`endif
    return v;
  endfunction
  function automatic int irq_exp(input bit b);
`ifdef BP_PERF_OVERFLOW_IRQ_EN
    return int'(b);
`else
    return 0;
`endif
  endfunction
  // reference model: one clock edge worth of behaviour, evaluated on pre-edge inputs
  task automatic step();
    bit acc;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        lw[k] = 0; ls[k] = 0; shw[k] = 0; shs[k] = 0; ovw[k] = 0; ovs[k] = 0;
      end
      irqw = 0; irqs = 0; mv = 0;
      qw.delete(); qs.delete();
      return;
    end
    acc = rv && (!mv || yumi);
    if (acc) begin
      qw.push_back(int'(raddr) < N ? shw[raddr] : 0);
      qs.push_back(int'(raddr) < N ? shs[raddr] : 0);
    end
    mv = acc || (mv && !yumi);
    irqw = 0; irqs = 0;
    for (int k = 0; k < N; k++) begin
      irqw |= ovw[k];
      irqs |= ovs[k];
    end
    if (snap) for (int k = 0; k < N; k++) begin
      shw[k] = lw[k]; shs[k] = ls[k];
    end
    for (int k = 0; k < N; k++) begin
      if (clr) begin
        lw[k] = 0; ls[k] = 0; ovw[k] = 0; ovs[k] = 0;
      end else if (en && ev[k]) begin
        if (lw[k] == MAXV) ovw[k] = 1;
        lw[k] = (lw[k] + 1) % (MAXV + 1);
        if (ls[k] == MAXV) ovs[k] = 1;
        else ls[k]++;
      end
    end
  endtask
  task automatic cyc();
    yumi = yumi_req && mv;
    @(negedge clk);
    if (rst_n) begin
      chk("ready_wrap", int'(rdy_w), int'(!mv || yumi));
      chk("ready_sat", int'(rdy_s), int'(!mv || yumi));
    end
    step();
    @(posedge clk);
    #1;
    chk("rd_v_wrap", int'(rvo_w), int'(mv));
    chk("rd_v_sat", int'(rvo_s), int'(mv));
    chk("ovf_wrap", int'(ovf_w_o), flags(ovw));
    chk("ovf_sat", int'(ovf_s_o), flags(ovs));
    chk("irq_wrap", int'(irq_w_o), irq_exp(irqw));
    chk("irq_sat", int'(irq_s_o), irq_exp(irqs));
    if (!rst_n) chk("reset_data", int'(rdo_w) + int'(rdo_s), 0);
  endtask
  // monitor: compare every presented response with the oldest expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rvo_w === 1'b1) begin
      if (qw.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        chk("rd_data_wrap", int'(rdo_w), qw[0]);
        chk("rd_data_sat", int'(rdo_s), qs[0]);
        if (yumi) begin
          void'(qw.pop_front());
          void'(qs.pop_front());
        end
      end
    end
  end
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic snap_cyc();
    snap = 1; cyc(); snap = 0;
  endtask
  task automatic read_all(input int last);
    for (int a = 0; a <= last; a++) begin
      rv = 1; raddr = 3'(a); yumi_req = 1; cyc();
    end
    rv = 0; cyc();
  endtask
  initial begin
    rst_n = 0; en = 1; clr = 0; snap = 0; rv = 0; yumi = 0; yumi_req = 0;
    ev = '1; raddr = '0;
    idle(3);
    rst_n = 1; ev = '0;
    snap_cyc();
    read_all(N - 1);
    ev = 5'b00101; idle(10);
    ev = '0; snap_cyc();
    read_all(3);
    clr = 1; cyc(); clr = 0;
    ev = 5'b00001; idle(17);
    ev = '0; snap_cyc();
    read_all(0);
    clr = 1; cyc(); clr = 0;
    ev = 5'b00001; idle(7);
    snap = 1; clr = 1; cyc(); snap = 0; clr = 0;
    ev = '0; read_all(0);
    ev = 5'b00001; cyc();
    ev = '0; snap_cyc();
    read_all(0);
    clr = 1; cyc(); clr = 0;
    ev = 5'b00010; idle(5);
    ev = '0; snap_cyc();
    rv = 1; raddr = 3'd1; yumi_req = 0; cyc();
    rv = 0; ev = 5'b00010; idle(4);
    ev = '0; snap_cyc();
    rv = 1; idle(2);
    yumi_req = 1; cyc();
    rv = 0; cyc();
    en = 0; ev = '1; idle(20);
    en = 1; ev = '0; snap_cyc();
    read_all(N);
    for (int i = 0; i < 1500; i++) begin
      rst_n = !(i == 700 || i == 701);
      en = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      ev = N'($urandom);
      snap = ($urandom_range(0, 7) == 0);
      rv = 1'($urandom_range(0, 1));
      raddr = 3'($urandom_range(0, 7));
      yumi_req = rst_n && ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst_n = 1; en = 0; clr = 0; ev = '0; snap = 0; rv = 0; yumi_req = 1;
    idle(3);
    chk("sb_drain", qw.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
